// File: rtl/sent_rx_serial_decoder_pkg.sv
// sent_rx_serial_decoder_pkg: SENT slow-channel frame counts and decoder state encoding.
// Package sent_pkg, shared by the serial decoder and its interface; no ports.
package sent_pkg;
    localparam logic [4:0] SHORT_FRAMES     = 5'd16;
    localparam logic [4:0] ENH_FRAMES       = 5'd18;
    localparam logic [4:0] ENH_PREAMBLE     = 5'd6;
    localparam logic [4:0] ENH_ZERO_FRAME_A = 5'd13;
    localparam logic [4:0] ENH_ZERO_FRAME_B = 5'd18;
    typedef enum logic [1:0] {HUNT, PREAMBLE, COLLECT} state_t;
endpackage

// File: rtl/sent_rx_serial_decoder_if.sv
// sent_rx_serial_decoder_if: bundle between the fast-frame decoder, the serial decoder and the CRC checker.
// Inputs to the decoder: serial_mode, status_valid, status_nibble[3:0], frame_error.
// Outputs from the decoder: enable_crc_check_serial, data_short_to_check_crc[15:0],
//   enable_crc_check_enhanced, data_enhanced_to_check_crc[29:0], enhanced_config, sync_lost.
// master = upstream/downstream side, slave = the serial decoder.
interface sent_rx_serial_decoder_if;
    logic        serial_mode;
    logic        status_valid;
    logic [3:0]  status_nibble;
    logic        frame_error;
    logic        enable_crc_check_serial;
    logic [15:0] data_short_to_check_crc;
    logic        enable_crc_check_enhanced;
    logic [29:0] data_enhanced_to_check_crc;
    logic        enhanced_config;
    logic        sync_lost;
    modport master (
        output serial_mode, status_valid, status_nibble, frame_error,
        input  enable_crc_check_serial, data_short_to_check_crc,
               enable_crc_check_enhanced, data_enhanced_to_check_crc,
               enhanced_config, sync_lost
    );
    modport slave (
        input  serial_mode, status_valid, status_nibble, frame_error,
        output enable_crc_check_serial, data_short_to_check_crc,
               enable_crc_check_enhanced, data_enhanced_to_check_crc,
               enhanced_config, sync_lost
    );
endinterface

// File: rtl/sent_rx_serial_decoder.sv
// sent_rx_serial_decoder: assembles SENT short/enhanced serial messages from fast-frame status nibbles.
// Ports: clk (receive clock), reset (sync, active-high), bus (sent_rx_serial_decoder_if.slave):
//   status nibbles in, packed messages + one-cycle completion/sync_lost pulses out, all registered.
module sent_rx_serial_decoder
    import sent_pkg::*;
(
    input logic clk,
    input logic reset,
    sent_rx_serial_decoder_if.slave bus
);
    state_t      r_state;
    logic [4:0]  r_cnt;
    logic        r_mode;
    logic [15:0] r_short_sr;
    logic [5:0]  r_crc_sr;
    logic [23:0] r_payload;
    logic        r_en_short;
    logic [15:0] r_data_short;
    logic        r_en_enh;
    logic [29:0] r_data_enh;
    logic        r_config;
    logic        r_sync_lost;

    logic        w_b3;
    logic        w_b2;
    logic [4:0]  w_cnt_inc;
    logic [15:0] w_short_nxt;
    logic [5:0]  w_crc_nxt;
    logic [23:0] w_payload_nxt;
    logic        w_unused;

    assign w_b3          = bus.status_nibble[3];
    assign w_b2          = bus.status_nibble[2];
    assign w_cnt_inc     = r_cnt + 5'd1;
    assign w_short_nxt   = {r_short_sr[14:0], w_b2};
    assign w_crc_nxt     = {r_crc_sr[4:0], w_b2};
    assign w_payload_nxt = {r_payload[21:0], w_b2, w_b3};
    assign w_unused      = ^bus.status_nibble[1:0];

    assign bus.enable_crc_check_serial    = r_en_short;
    assign bus.data_short_to_check_crc    = r_data_short;
    assign bus.enable_crc_check_enhanced  = r_en_enh;
    assign bus.data_enhanced_to_check_crc = r_data_enh;
    assign bus.enhanced_config            = r_config;
    assign bus.sync_lost                  = r_sync_lost;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= HUNT;
            r_cnt        <= 5'd0;
            r_mode       <= 1'b0;
            r_short_sr   <= 16'd0;
            r_crc_sr     <= 6'd0;
            r_payload    <= 24'd0;
            r_en_short   <= 1'b0;
            r_data_short <= 16'd0;
            r_en_enh     <= 1'b0;
            r_data_enh   <= 30'd0;
            r_config     <= 1'b0;
            r_sync_lost  <= 1'b0;
        end else begin
            r_en_short  <= 1'b0;
            r_en_enh    <= 1'b0;
            r_sync_lost <= 1'b0;
            r_mode      <= bus.serial_mode;
            // a format switch silently drops whatever was in progress
            if (bus.serial_mode != r_mode) begin
                r_state <= HUNT;
                r_cnt   <= 5'd0;
            end else if (bus.frame_error) begin
                r_sync_lost <= (r_state != HUNT);
                r_state     <= HUNT;
                r_cnt       <= 5'd0;
            end else if (bus.status_valid) begin
                if (!r_mode) begin
                    // b3=1 always starts a new short message, aborting any open one
                    if (w_b3) begin
                        r_sync_lost <= (r_state == COLLECT);
                        r_short_sr  <= w_short_nxt;
                        r_cnt       <= 5'd1;
                        r_state     <= COLLECT;
                    end else if (r_state == COLLECT) begin
                        r_short_sr <= w_short_nxt;
                        r_cnt      <= w_cnt_inc;
                        if (w_cnt_inc == SHORT_FRAMES) begin
                            r_en_short   <= 1'b1;
                            r_data_short <= w_short_nxt;
                            r_state      <= HUNT;
                        end
                    end
                end else if (r_state != COLLECT) begin
                    // preamble frames feed the crc; longer runs keep only the last six
                    if (w_b3) begin
                        r_crc_sr <= w_crc_nxt;
                        r_cnt    <= (r_state == HUNT) ? 5'd1 : (r_cnt == ENH_PREAMBLE) ? ENH_PREAMBLE : w_cnt_inc;
                        r_state  <= PREAMBLE;
                    end else if (r_state == PREAMBLE) begin
                        r_cnt     <= (r_cnt == ENH_PREAMBLE) ? w_cnt_inc : 5'd0;
                        r_payload <= w_payload_nxt;
                        r_state   <= (r_cnt == ENH_PREAMBLE) ? COLLECT : HUNT;
                    end
                end else if (w_b3 && (w_cnt_inc == ENH_ZERO_FRAME_A || w_cnt_inc == ENH_ZERO_FRAME_B)) begin
                    // the offending b3=1 frame is taken as preamble frame 1 of a new message
                    r_sync_lost <= 1'b1;
                    r_crc_sr    <= w_crc_nxt;
                    r_cnt       <= 5'd1;
                    r_state     <= PREAMBLE;
                end else begin
                    r_payload <= w_payload_nxt;
                    r_cnt     <= w_cnt_inc;
                    if (w_cnt_inc == ENH_FRAMES) begin
                        r_en_enh   <= 1'b1;
                        r_data_enh <= {w_payload_nxt, r_crc_sr};
                        r_config   <= w_payload_nxt[20];
                        r_state    <= HUNT;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_sent_rx_serial_decoder.sv
// tb_sent_rx_serial_decoder: directed self-checking bench for the SENT serial message decoder.
module tb_sent_rx_serial_decoder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;
    int n_short = 0;
    int n_enh = 0;
    int n_sync = 0;
    int s0, e0, y0;

    sent_rx_serial_decoder_if bus();
    sent_rx_serial_decoder dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.enable_crc_check_serial) n_short++;
        if (bus.enable_crc_check_enhanced) n_enh++;
        if (bus.sync_lost) n_sync++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        s0 = n_short;
        e0 = n_enh;
        y0 = n_sync;
    endtask

    task automatic deltas(input string tag, input int ds, input int de, input int dy);
        idle(2);
        check({tag, "_short_pulses"}, 32'(n_short - s0), 32'(ds));
        check({tag, "_enh_pulses"}, 32'(n_enh - e0), 32'(de));
        check({tag, "_sync_pulses"}, 32'(n_sync - y0), 32'(dy));
    endtask

    task automatic frame(input logic b3, input logic b2);
        bus.status_valid = 1'b1;
        bus.status_nibble = {b3, b2, 2'b00};
        @(negedge clk);
        bus.status_valid = 1'b0;
        bus.status_nibble = 4'd0;
    endtask

    task automatic frame_err();
        bus.frame_error = 1'b1;
        @(negedge clk);
        bus.frame_error = 1'b0;
    endtask

    task automatic send_short(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) frame(i == 0, v[15-i]);
    endtask

    task automatic send_enh(input logic [5:0] c, input logic [23:0] p, input int pre, input int n);
        int off;
        off = (pre > 6) ? pre - 6 : 0;
        for (int k = 0; k < pre; k++) frame(1'b1, (k < off) ? 1'b1 : c[5-(k-off)]);
        for (int j = 0; j < 12 && pre + j < n; j++) frame(p[22-2*j], p[23-2*j]);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_en_short"}, 32'(bus.enable_crc_check_serial), 32'd0);
        check({tag, "_data_short"}, 32'(bus.data_short_to_check_crc), 32'd0);
        check({tag, "_en_enh"}, 32'(bus.enable_crc_check_enhanced), 32'd0);
        check({tag, "_data_enh"}, 32'(bus.data_enhanced_to_check_crc), 32'd0);
        check({tag, "_config"}, 32'(bus.enhanced_config), 32'd0);
        check({tag, "_sync"}, 32'(bus.sync_lost), 32'd0);
    endtask

    initial begin
        logic [15:0] b;
        bus.serial_mode = 1'b0;
        bus.status_valid = 1'b0;
        bus.status_nibble = 4'd0;
        bus.frame_error = 1'b0;
        idle(3);
        reset = 1'b0;
        idle(1);
        check_zero("reset");

        snap();
        send_short(16'h2C7D, 16);
        check("short_en", 32'(bus.enable_crc_check_serial), 32'd1);
        check("short_data", 32'(bus.data_short_to_check_crc), 32'h2C7D);
        deltas("short", 1, 0, 0);

        snap();
        send_short(16'h8001, 16);
        send_short(16'h4E21, 16);
        check("b2b_en", 32'(bus.enable_crc_check_serial), 32'd1);
        check("b2b_data", 32'(bus.data_short_to_check_crc), 32'h4E21);
        deltas("b2b", 2, 0, 0);

        snap();
        b = 16'hA5C3;
        send_short(16'hFFFF, 8);
        frame(1'b1, b[15]);
        check("restart_sync", 32'(bus.sync_lost), 32'd1);
        for (int i = 1; i < 16; i++) frame(1'b0, b[15-i]);
        check("restart_en", 32'(bus.enable_crc_check_serial), 32'd1);
        check("restart_data", 32'(bus.data_short_to_check_crc), 32'hA5C3);
        deltas("restart", 1, 0, 1);

        snap();
        send_short(16'h1234, 9);
        frame_err();
        check("short_ferr_sync", 32'(bus.sync_lost), 32'd1);
        deltas("short_ferr", 0, 0, 1);

        snap();
        bus.frame_error = 1'b1;
        frame(1'b1, 1'b0);
        bus.frame_error = 1'b0;
        for (int i = 0; i < 15; i++) frame(1'b0, 1'b1);
        deltas("simul", 0, 0, 0);
        check("simul_hold", 32'(bus.data_short_to_check_crc), 32'hA5C3);

        bus.serial_mode = 1'b1;
        idle(2);
        snap();
        send_enh(6'h2A, 24'h123052, 6, 18);
        check("enh_en", 32'(bus.enable_crc_check_enhanced), 32'd1);
        check("enh_data", 32'(bus.data_enhanced_to_check_crc), 32'({24'h123052, 6'h2A}));
        check("enh_config", 32'(bus.enhanced_config), 32'd1);
        deltas("enh", 0, 1, 0);

        snap();
        send_enh(6'h15, 24'h812344, 7, 19);
        check("pre7_en", 32'(bus.enable_crc_check_enhanced), 32'd1);
        check("pre7_data", 32'(bus.data_enhanced_to_check_crc), 32'({24'h812344, 6'h15}));
        check("pre7_config", 32'(bus.enhanced_config), 32'd0);
        deltas("pre7", 0, 1, 0);

        snap();
        send_enh(6'h3F, 24'h000000, 5, 17);
        deltas("pre5", 0, 0, 0);
        check("pre5_hold", 32'(bus.data_enhanced_to_check_crc), 32'({24'h812344, 6'h15}));

        snap();
        send_enh(6'h01, 24'h000400, 6, 18);
        deltas("zero13", 0, 0, 1);

        snap();
        send_enh(6'h2A, 24'h123052, 6, 9);
        frame_err();
        check("enh_ferr_sync", 32'(bus.sync_lost), 32'd1);
        deltas("enh_ferr", 0, 0, 1);

        bus.serial_mode = 1'b0;
        idle(2);
        snap();
        send_short(16'hC3C3, 4);
        bus.serial_mode = 1'b1;
        for (int i = 4; i < 16; i++) frame(1'b0, 1'b1);
        bus.serial_mode = 1'b0;
        deltas("mode_toggle", 0, 0, 0);

        snap();
        send_short(16'h7777, 11);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        check_zero("midreset");
        for (int i = 11; i < 16; i++) frame(1'b0, 1'b1);
        deltas("midreset", 0, 0, 0);

        snap();
        send_short(16'hBEEF, 16);
        check("post_reset_data", 32'(bus.data_short_to_check_crc), 32'hBEEF);
        deltas("post_reset", 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
